mem_port_arbiter: RTL and testbench

//  Shares one single-port synchronous memory between the core's instruction-fetch

---
 rtl/mem_port_arbiter.sv | 93 +++++++++
 tb/tb_mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Per-cycle arbiter sharing one single-port synchronous memory between instruction
// fetch (IF) and load/store (D). D has fixed priority; a starvation counter forces IF through.
module mem_port_arbiter #(
   parameter int WORD_LEN = 32,
   parameter int MAX_WAIT = 4,
   parameter int CNT_W    = 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                if_req,
   input  logic [WORD_LEN-1:0] if_addr,
   output logic                if_gnt,
   output logic                if_rvalid,
   output logic [WORD_LEN-1:0] if_rdata,
   output logic                if_stall,
   input  logic                d_req,
   input  logic                d_we,
   input  logic [WORD_LEN-1:0] d_addr,
   input  logic [WORD_LEN-1:0] d_wdata,
   output logic                d_gnt,
   output logic                d_rvalid,
   output logic [WORD_LEN-1:0] d_rdata,
   output logic                mem_en,
   output logic                mem_we,
   output logic [WORD_LEN-1:0] mem_addr,
   output logic [WORD_LEN-1:0] mem_wdata,
   input  logic [WORD_LEN-1:0] mem_rdata
);

   typedef struct packed {
      logic                en;
      logic                we;
      logic [WORD_LEN-1:0] addr;
      logic [WORD_LEN-1:0] wdata;
   } mem_req_t;

   logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
   logic             rsp_if_q, rsp_if_d;
   logic             rsp_d_q, rsp_d_d;
   logic             starve, if_win, d_win;
   mem_req_t         mreq;

   // Grants are gated by rst_n so nothing reaches the memory while reset is held.
   always_comb begin
      starve = (wait_cnt_q >= CNT_W'(MAX_WAIT));
      if_win = rst_n & if_req & (~d_req | starve);
      d_win  = rst_n & d_req & ~if_win;
      mreq   = '0;
      if (if_win) begin
         mreq.en   = 1'b1;
         mreq.addr = if_addr;
      end else if (d_win) begin
         mreq.en    = 1'b1;
         mreq.we    = d_we;
         mreq.addr  = d_addr;
         mreq.wdata = d_wdata;
      end
   end

   always_comb begin
      wait_cnt_d = '0;
      if (if_req & ~if_win)
         wait_cnt_d = starve ? wait_cnt_q : wait_cnt_q + CNT_W'(1);
      rsp_if_d = if_win;
      rsp_d_d  = d_win & ~d_we;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wait_cnt_q <= '0;
         rsp_if_q   <= 1'b0;
         rsp_d_q    <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         rsp_if_q   <= rsp_if_d;
         rsp_d_q    <= rsp_d_d;
      end
   end

   assign if_gnt    = if_win;
   assign d_gnt     = d_win;
   assign if_stall  = if_req & ~if_win;
   assign mem_en    = mreq.en;
   assign mem_we    = mreq.we;
   assign mem_addr  = mreq.addr;
   assign mem_wdata = mreq.wdata;

   assign if_rvalid = rsp_if_q;
   assign d_rvalid  = rsp_d_q;
   assign if_rdata  = rsp_if_q ? mem_rdata : '0;
   assign d_rdata   = rsp_d_q  ? mem_rdata : '0;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: directed scenarios with literal expectations, then
// randomized IF/D traffic checked every cycle against a queue-free behavioural model.
module tb_mem_port_arbiter;
   localparam int W        = 32;
   localparam int MAX_WAIT = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          if_req, d_req, d_we;
   logic [W-1:0]  if_addr, d_addr, d_wdata;
   logic          if_gnt, if_rvalid, if_stall, d_gnt, d_rvalid;
   logic [W-1:0]  if_rdata, d_rdata;
   logic          mem_en, mem_we;
   logic [W-1:0]  mem_addr, mem_wdata, mem_rdata;

   int errors = 0;
   int checks = 0;

   mem_port_arbiter #(.WORD_LEN(W), .MAX_WAIT(MAX_WAIT), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt), .if_rvalid(if_rvalid),
      .if_rdata(if_rdata), .if_stall(if_stall),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
      end
   endtask

   function automatic logic [W-1:0] init_val(input int i);
      return (i == 16) ? 32'h3433_3231 : ({4{8'(i)}} ^ 32'hA5A5_0F0F);
   endfunction

   // Memory seen by the DUT: 32 words, garbage on mem_rdata whenever no read was issued
   logic [W-1:0] sram [32];
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < 32; i++) sram[i] <= init_val(i);
         mem_rdata <= '0;
      end else begin
         if (mem_en && mem_we) sram[mem_addr[4:0]] <= mem_wdata;
         mem_rdata <= (mem_en && !mem_we) ? sram[mem_addr[4:0]] : $urandom;
      end
   end

   // Behavioural model: denial count, pending response owner and its expected data
   int           denials = 0;
   bit           pend_if = 1'b0, pend_d = 1'b0;
   logic [W-1:0] pend_if_data, pend_d_data;
   logic [W-1:0] mref [32];
   bit           m_if, m_d;

   always_comb begin
      m_if = rst_n && if_req && (!d_req || denials >= MAX_WAIT);
      m_d  = rst_n && d_req && !m_if;
   end

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         denials <= 0;
         pend_if <= 1'b0;
         pend_d  <= 1'b0;
         for (int i = 0; i < 32; i++) mref[i] <= init_val(i);
      end else begin
         pend_if      <= m_if;
         pend_if_data <= mref[if_addr[4:0]];
         pend_d       <= m_d && !d_we;
         pend_d_data  <= mref[d_addr[4:0]];
         if (m_d && d_we) mref[d_addr[4:0]] <= d_wdata;
         if (if_req && !m_if) denials <= (denials < MAX_WAIT) ? denials + 1 : MAX_WAIT;
         else                 denials <= 0;
      end
   end

   always @(negedge clk) begin
      chk1("if_gnt", if_gnt, m_if);
      chk1("d_gnt", d_gnt, m_d);
      chk1("mem_en", mem_en, m_if || m_d);
      chk1("mem_we", mem_we, m_d && d_we);
      chk("mem_addr", mem_addr, m_if ? if_addr : (m_d ? d_addr : '0));
      chk("mem_wdata", mem_wdata, m_d ? d_wdata : '0);
      chk1("if_stall", if_stall, if_req && !m_if);
      chk1("if_rvalid", if_rvalid, pend_if);
      chk1("d_rvalid", d_rvalid, pend_d);
      chk("if_rdata", if_rdata, pend_if ? pend_if_data : '0);
      chk("d_rdata", d_rdata, pend_d ? pend_d_data : '0);
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   logic [9:0] if_seq, d_seq;
   logic [7:0] if_seq5;
   logic       gi, gd;

   initial begin
      rst_n = 1'b0;
      if_req = 1'b1; if_addr = 32'h8;
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h4; d_wdata = '0;

      // Reset holds everything off even with both requests up
      @(negedge clk);
      chk1("rst if_gnt", if_gnt, 1'b0);
      chk1("rst d_gnt", d_gnt, 1'b0);
      chk1("rst mem_en", mem_en, 1'b0);
      chk1("rst if_rvalid", if_rvalid, 1'b0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk1("post-rst d_gnt", d_gnt, 1'b1);
      chk1("post-rst if_gnt", if_gnt, 1'b0);

      // IF only, read data returns one cycle later
      step();
      if_req = 1'b1; if_addr = 32'h10; d_req = 1'b0;
      @(negedge clk);
      chk1("ifonly gnt", if_gnt, 1'b1);
      chk("ifonly addr", mem_addr, 32'h10);
      chk1("ifonly we", mem_we, 1'b0);
      step();
      if_req = 1'b0;
      @(negedge clk);
      chk1("ifonly rvalid", if_rvalid, 1'b1);
      chk("ifonly rdata", if_rdata, 32'h3433_3231);
      chk1("ifonly d_rvalid", d_rvalid, 1'b0);

      // Sustained contention: IF forced through every 5th cycle
      step();
      step();
      if_req = 1'b1; if_addr = 32'h5; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3;
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         if_seq[i] = if_gnt;
         d_seq[i]  = d_gnt;
         if (!if_gnt) chk1("contend stall", if_stall, 1'b1);
         step();
      end
      chk("contend if seq", 32'(if_seq), 32'h210);
      chk("contend d seq", 32'(d_seq), 32'h1EF);
      if_req = 1'b0; d_req = 1'b0;

      // Store: written, no response
      step();
      d_req = 1'b1; d_we = 1'b1; d_addr = 32'h20; d_wdata = 32'hDEAD_BEEF;
      @(negedge clk);
      chk1("store we", mem_we, 1'b1);
      chk("store wdata", mem_wdata, 32'hDEAD_BEEF);
      chk1("store gnt", d_gnt, 1'b1);
      step();
      d_req = 1'b0; d_we = 1'b0;
      @(negedge clk);
      chk1("store no rvalid", d_rvalid, 1'b0);

      // Counter clear: D drops after 2 denials, next contention needs 4 denials again
      step();
      if_req = 1'b1; if_addr = 32'h7; d_addr = 32'h9;
      for (int i = 0; i < 8; i++) begin
         d_req = (i != 2);
         @(negedge clk);
         if_seq5[i] = if_gnt;
         step();
      end
      chk("clear if seq", 32'(if_seq5), 32'h84);
      if_req = 1'b0; d_req = 1'b0;

      // Async reset while a load response is in flight
      step();
      d_req = 1'b1; d_we = 1'b0; d_addr = 32'h11;
      @(negedge clk);
      chk1("inflight gnt", d_gnt, 1'b1);
      @(posedge clk);
      #2;
      d_req = 1'b0;
      chk1("inflight rvalid", d_rvalid, 1'b1);
      #1 rst_n = 1'b0;
      #1 chk1("async rst rvalid", d_rvalid, 1'b0);
      step();
      rst_n = 1'b1;
      @(negedge clk);
      chk1("after rst rvalid", d_rvalid, 1'b0);

      // Randomized traffic: requests held until granted, occasionally dropped
      for (int n = 0; n < 3000; n++) begin
         @(negedge clk);
         gi = if_gnt;
         gd = d_gnt;
         step();
         if (!if_req || gi) begin
            if_req  = ($urandom_range(0, 3) != 0);
            if_addr = $urandom_range(0, 31);
         end else if ($urandom_range(0, 19) == 0) begin
            if_req = 1'b0;
         end
         if (!d_req || gd) begin
            d_req   = ($urandom_range(0, 3) != 0);
            d_we    = ($urandom_range(0, 2) == 0);
            d_addr  = $urandom_range(0, 31);
            d_wdata = $urandom;
         end else if ($urandom_range(0, 19) == 0) begin
            d_req = 1'b0;
         end
      end
      @(negedge clk);
      #1;
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
